axis_traffic_gen: RTL and testbench

AXIS_TRAFFIC_GEN -- requirements
Module: axis_traffic_gen

---
 rtl/axis_traffic_gen.sv | 186 ++++++++++++++++++
 tb/tb_axis_traffic_gen.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_traffic_gen.sv
// axis_traffic_gen: synthetic AXI-Stream traffic source for network-on-chip testing.
// A 32-bit Galois LFSR drives both the per-cycle injection decision and the
// destination choice. Each emitted flit carries a timestamp in its upper half
// and a per-destination sequence number in its low COUNT_WIDTH bits.
// Optional build macro: AXIS_TRAFFIC_GEN_SKIP_SELF_EN. When defined, a flit
// that would be addressed to this source's own TID is redirected to
// (TID+1) mod NUM_ROUTERS.
module axis_traffic_gen #(
  parameter int          COUNT_WIDTH = 32,
  parameter int          TID         = 0,
  parameter int          TDATA_WIDTH = 512,
  parameter int          TDEST_WIDTH = 2,
  parameter int          TID_WIDTH   = 2,
  parameter int          NUM_ROUTERS = 4,
  parameter logic [31:0] SEED        = 32'h1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [TDATA_WIDTH/2-1:0]                ticks,
  input  logic                                    enable,
  input  logic [8:0]                              inject_rate,
  input  logic [COUNT_WIDTH-1:0]                  num_packets,
  output logic [NUM_ROUTERS-1:0][COUNT_WIDTH-1:0] sent_packets,
  output logic [COUNT_WIDTH-1:0]                  total_sent_packets,
  output logic                                    done,
  output logic                                    axis_out_tvalid,
  input  logic                                    axis_out_tready,
  output logic [TDATA_WIDTH-1:0]                  axis_out_tdata,
  output logic                                    axis_out_tlast,
  output logic [TID_WIDTH-1:0]                    axis_out_tid,
  output logic [TDEST_WIDTH-1:0]                  axis_out_tdest
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_VALID  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [31:0] LFSR_INIT = (SEED == 32'h0) ? 32'h1 : SEED;

  logic [1:0]             state_reg, state_next;
  logic [31:0]            lfsr_reg, lfsr_step;
  logic                   advance, load, handshake, inject, budget_hit;
  logic [TDEST_WIDTH-1:0] dest_raw, dest_sel;
  logic [COUNT_WIDTH-1:0] cnt_reg [NUM_ROUTERS];
  logic [COUNT_WIDTH-1:0] total_reg, total_inc, seq_sel;
  logic [NUM_ROUTERS-1:0] hit;
  logic [TDATA_WIDTH-1:0] tdata_new;

  logic                   tvalid_reg, tlast_reg;
  logic [TDATA_WIDTH-1:0] tdata_reg;
  logic [TDEST_WIDTH-1:0] tdest_reg;
  logic [TID_WIDTH-1:0]   tid_reg;

  assign handshake  = tvalid_reg && axis_out_tready;
  assign lfsr_step  = {1'b0, lfsr_reg[31:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 32'h0);
  assign inject     = ({1'b0, lfsr_reg[7:0]} < inject_rate);
  assign total_inc  = total_reg + COUNT_WIDTH'(1);
  assign budget_hit = (num_packets != '0) && (total_inc == num_packets);
  assign dest_raw   = TDEST_WIDTH'(lfsr_reg[31:16] % 16'(NUM_ROUTERS));

`ifdef AXIS_TRAFFIC_GEN_SKIP_SELF_EN
  localparam logic [TDEST_WIDTH-1:0] SELF_DEST = TDEST_WIDTH'(TID);
  localparam logic [TDEST_WIDTH-1:0] SKIP_DEST = TDEST_WIDTH'((TID + 1) % NUM_ROUTERS);
  assign dest_sel = (dest_raw == SELF_DEST) ? SKIP_DEST : dest_raw;
`else
  assign dest_sel = dest_raw;
`endif

  // Per-destination handshake strobes and counter fan-out to the output bus.
  for (genvar gi = 0; gi < NUM_ROUTERS; gi++) begin : g_dest
    assign hit[gi]          = handshake && (tdest_reg == TDEST_WIDTH'(gi));
    assign sent_packets[gi] = cnt_reg[gi];
  end

  // Sequence number for the next flit; includes a same-edge handshake to that destination.
  always_comb begin
    seq_sel = '0;
    for (int i = 0; i < NUM_ROUTERS; i++) begin
      if (dest_sel == TDEST_WIDTH'(i)) begin
        seq_sel = cnt_reg[i] + (hit[i] ? COUNT_WIDTH'(1) : COUNT_WIDTH'(0));
      end
    end
  end

  // Flit payload: timestamp in the upper half, sequence number in the low bits.
  always_comb begin
    tdata_new = '0;
    tdata_new[TDATA_WIDTH-1 -: TDATA_WIDTH/2] = ticks;
    tdata_new[COUNT_WIDTH-1:0] = seq_sel;
  end

  // Next-state logic; a presented flit is never withdrawn before its handshake.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    advance    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (enable) state_next = S_ACTIVE;
      end
      S_ACTIVE: begin
        advance = 1'b1;
        if (!enable) begin
          state_next = S_IDLE;
        end else if (inject) begin
          load       = 1'b1;
          state_next = S_VALID;
        end
      end
      S_VALID: begin
        if (handshake) begin
          advance = 1'b1;
          if (inject && enable && !budget_hit) begin
            load = 1'b1;
          end else if (budget_hit) begin
            state_next = S_DONE;
          end else if (enable) begin
            state_next = S_ACTIVE;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      S_DONE: begin
        if (!enable) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register and LFSR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      lfsr_reg  <= LFSR_INIT;
    end else begin
      state_reg <= state_next;
      if (advance) lfsr_reg <= lfsr_step;
    end
  end

  // Output flit register; fields only change when a new flit is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tvalid_reg <= 1'b0;
      tdata_reg  <= '0;
      tdest_reg  <= '0;
      tid_reg    <= '0;
      tlast_reg  <= 1'b0;
    end else begin
      tvalid_reg <= (state_next == S_VALID);
      if (load) begin
        tdata_reg <= tdata_new;
        tdest_reg <= dest_sel;
        tid_reg   <= TID_WIDTH'(TID);
        tlast_reg <= 1'b1;
      end
    end
  end

  // Handshake counters, wrapping modulo 2**COUNT_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ROUTERS; i++) cnt_reg[i] <= '0;
      total_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_ROUTERS; i++) begin
        if (hit[i]) cnt_reg[i] <= cnt_reg[i] + COUNT_WIDTH'(1);
      end
      if (handshake) total_reg <= total_inc;
    end
  end

  assign total_sent_packets = total_reg;
  assign done               = (state_reg == S_DONE);
  assign axis_out_tvalid    = tvalid_reg;
  assign axis_out_tdata     = tdata_reg;
  assign axis_out_tdest     = tdest_reg;
  assign axis_out_tid       = tid_reg;
  assign axis_out_tlast     = tlast_reg;

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Testbench for axis_traffic_gen: randomized stimulus against a cycle-level
// behavioural reference model. Inputs are driven and outputs sampled on the
// falling clock edge.
module tb_axis_traffic_gen;

  localparam int CW   = 32;
  localparam int TDW  = 512;
  localparam int DW   = 2;
  localparam int IW   = 2;
  localparam int NR   = 4;
  localparam int TIDP = 1;
  localparam logic [31:0] SEEDP = 32'h1;
  localparam int VW   = 1 + TDW + DW + IW + 1 + CW + 1 + NR*CW;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic [TDW/2-1:0]         ticks = '0;
  logic                     enable = 1'b0;
  logic [8:0]               inject_rate = '0;
  logic [CW-1:0]            num_packets = '0;
  logic [NR-1:0][CW-1:0]    sent_packets;
  logic [CW-1:0]            total_sent_packets;
  logic                     done;
  logic                     axis_out_tvalid;
  logic                     axis_out_tready = 1'b0;
  logic [TDW-1:0]           axis_out_tdata;
  logic                     axis_out_tlast;
  logic [IW-1:0]            axis_out_tid;
  logic [DW-1:0]            axis_out_tdest;

  axis_traffic_gen #(
    .COUNT_WIDTH(CW), .TID(TIDP), .TDATA_WIDTH(TDW), .TDEST_WIDTH(DW),
    .TID_WIDTH(IW), .NUM_ROUTERS(NR), .SEED(SEEDP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ticks(ticks), .enable(enable),
    .inject_rate(inject_rate), .num_packets(num_packets),
    .sent_packets(sent_packets), .total_sent_packets(total_sent_packets),
    .done(done), .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready),
    .axis_out_tdata(axis_out_tdata), .axis_out_tlast(axis_out_tlast),
    .axis_out_tid(axis_out_tid), .axis_out_tdest(axis_out_tdest)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int seen [NR];

  // ---------------- reference model ----------------
  int                    m_mode;   // 0 idle, 1 active, 2 presenting flit, 3 budget exhausted
  logic [31:0]           m_lfsr;
  logic                  m_tvalid;
  logic [TDW-1:0]        m_tdata;
  logic [DW-1:0]         m_tdest;
  logic [CW-1:0]         m_total;
  logic [NR-1:0][CW-1:0] m_sent;

  // One step of the generator polynomial x^32+x^22+x^2+x+1 (feedback into bits 31,21,1,0).
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    logic [31:0] taps;
    taps = (32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1;
    return (v >> 1) ^ (v[0] ? taps : 32'h0);
  endfunction

  task automatic model_reset();
    m_mode   = 0;
    m_lfsr   = (SEEDP == 32'h0) ? 32'h1 : SEEDP;
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tdest  = '0;
    m_total  = '0;
    m_sent   = '0;
    for (int i = 0; i < NR; i++) seen[i] = 0;
  endtask

  task automatic new_flit(input int d);
    logic [TDW-1:0] w;
    w = '0;
    w[TDW-1 -: TDW/2] = ticks;
    w[CW-1:0] = m_sent[d];
    m_tvalid = 1'b1;
    m_tdest  = DW'(d);
    m_tdata  = w;
  endtask

  // Applies the generator rules for one rising edge, using the inputs currently driven.
  task automatic model_clock();
    logic [31:0] l;
    bit inj, hs, budget;
    int d;
    l   = m_lfsr;
    inj = (int'(l[7:0]) < int'(inject_rate));
    hs  = m_tvalid && axis_out_tready;
    d   = int'(l[31:16]) % NR;
`ifdef AXIS_TRAFFIC_GEN_SKIP_SELF_EN
    if (d == TIDP) d = (TIDP + 1) % NR;
`endif
    case (m_mode)
      0: if (enable) m_mode = 1;
      1: begin
        m_lfsr = lfsr_next(l);
        if (!enable) m_mode = 0;
        else if (inj) begin new_flit(d); m_mode = 2; end
      end
      2: if (hs) begin
        m_sent[m_tdest] = m_sent[m_tdest] + 1;
        m_total  = m_total + 1;
        m_lfsr   = lfsr_next(l);
        budget   = (num_packets != 0) && (m_total == num_packets);
        m_tvalid = 1'b0;
        if (inj && enable && !budget) new_flit(d);
        else if (budget) m_mode = 3;
        else m_mode = enable ? 1 : 0;
      end
      3: if (!enable) m_mode = 0;
      default: m_mode = 0;
    endcase
  endtask

  function automatic logic [VW-1:0] expected();
    return {m_tvalid, m_tvalid ? {m_tdata, m_tdest, IW'(TIDP), 1'b1} : {(TDW+DW+IW+1){1'b0}},
            m_total, (m_mode == 3), m_sent};
  endfunction

  logic [VW-1:0] obs;
  assign obs = {axis_out_tvalid,
                axis_out_tvalid ? {axis_out_tdata, axis_out_tdest, axis_out_tid, axis_out_tlast}
                                : {(TDW+DW+IW+1){1'b0}},
                total_sent_packets, done, sent_packets};

  // ---------------- sequencing ----------------
  task automatic step();
    if (rst_n === 1'b1) model_clock();
    @(negedge clk);
    ticks = ticks + 1'b1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until_valid(input int limit, output bit ok, inout int bad);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (obs !== expected()) bad++;
      if (axis_out_tvalid === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    enable = 1'b0; inject_rate = 9'd256; num_packets = '0; axis_out_tready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (axis_out_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", axis_out_tvalid); else passed++;
    checks++; if (axis_out_tdata !== '0) $display("FAIL reset_tdata: got %h want 0", axis_out_tdata[63:0]); else passed++;
    checks++; if (axis_out_tdest !== '0) $display("FAIL reset_tdest: got %0d want 0", axis_out_tdest); else passed++;
    checks++; if (axis_out_tid !== '0) $display("FAIL reset_tid: got %0d want 0", axis_out_tid); else passed++;
    checks++; if (axis_out_tlast !== 1'b0) $display("FAIL reset_tlast: got %b want 0", axis_out_tlast); else passed++;
    checks++; if (total_sent_packets !== '0) $display("FAIL reset_total: got %0d want 0", total_sent_packets); else passed++;
    checks++; if (sent_packets !== '0) $display("FAIL reset_sent: got %h want 0", sent_packets); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    step();
    checks++; if (axis_out_tvalid !== 1'b0) $display("FAIL first_flit_early: tvalid got %b want 0 one cycle after release", axis_out_tvalid); else passed++;
    step();
    checks++; if (axis_out_tvalid !== 1'b1) $display("FAIL first_flit_latency: tvalid got %b want 1 two cycles after release", axis_out_tvalid); else passed++;
    checks++; if (obs !== expected()) $display("FAIL first_flit_fields: tdest got %0d want %0d, seq got %0d want %0d", axis_out_tdest, m_tdest, axis_out_tdata[CW-1:0], m_tdata[CW-1:0]); else passed++;
    $display("test_reset done");
  endtask

  task automatic test_budget();
    int bad = 0, flits = 0, first = -1, last = -1;
    logic [CW-1:0] sum;
    apply_reset();
    num_packets = 8; inject_rate = 9'd256; axis_out_tready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 40 && done !== 1'b1; i++) begin
      step();
      if (obs !== expected()) bad++;
      if (axis_out_tvalid === 1'b1) begin flits++; if (first < 0) first = i; last = i; end
    end
    sum = '0;
    for (int i = 0; i < NR; i++) sum = sum + sent_packets[i];
    checks++; if (bad != 0) $display("FAIL budget_model: got %0d mismatching cycles want 0", bad); else passed++;
    checks++; if (flits != 8) $display("FAIL budget_flits: got %0d want 8", flits); else passed++;
    checks++; if (last - first != 7) $display("FAIL budget_consecutive: span got %0d want 7", last - first); else passed++;
    checks++; if (sum !== 8) $display("FAIL budget_sum_sent: got %0d want 8", sum); else passed++;
    checks++; if (total_sent_packets !== 8) $display("FAIL budget_total: got %0d want 8", total_sent_packets); else passed++;
    checks++; if (done !== 1'b1) $display("FAIL budget_done: got %b want 1", done); else passed++;
    checks++; if (axis_out_tvalid !== 1'b0) $display("FAIL budget_tvalid_after: got %b want 0", axis_out_tvalid); else passed++;
    enable = 1'b0;
    step();
    checks++; if (done !== 1'b0) $display("FAIL done_to_idle: done got %b want 0", done); else passed++;
    $display("test_budget done: %0d flits", flits);
  endtask

  task automatic test_backpressure();
    int bad = 0, unstable = 0;
    bit ok;
    logic [TDW-1:0] d0;
    logic [DW-1:0] t0;
    apply_reset();
    num_packets = '0; inject_rate = 9'd256; axis_out_tready = 1'b0; enable = 1'b1;
    run_until_valid(10, ok, bad);
    checks++; if (!ok) $display("FAIL bp_wait_valid: tvalid got %b want 1 within 10 cycles", axis_out_tvalid); else passed++;
    d0 = axis_out_tdata; t0 = axis_out_tdest;
    for (int i = 0; i < 10; i++) begin
      step();
      if (obs !== expected()) bad++;
      if (axis_out_tvalid !== 1'b1 || axis_out_tdata !== d0 || axis_out_tdest !== t0 || total_sent_packets !== '0)
        unstable++;
    end
    checks++; if (unstable != 0) $display("FAIL bp_hold: got %0d unstable cycles want 0", unstable); else passed++;
    checks++; if (total_sent_packets !== '0) $display("FAIL bp_total_before: got %0d want 0", total_sent_packets); else passed++;
    axis_out_tready = 1'b1;
    step();
    if (obs !== expected()) bad++;
    checks++; if (total_sent_packets !== 1) $display("FAIL bp_total_after: got %0d want 1", total_sent_packets); else passed++;
    checks++; if (sent_packets[t0] !== 1) $display("FAIL bp_sent_dest: got %0d want 1", sent_packets[t0]); else passed++;
    checks++; if (bad != 0) $display("FAIL bp_model: got %0d mismatching cycles want 0", bad); else passed++;
    $display("test_backpressure done: dest %0d", t0);
  endtask

  task automatic test_enable_drop();
    int bad = 0, dropped = 0;
    bit ok;
    apply_reset();
    num_packets = '0; inject_rate = 9'd256; axis_out_tready = 1'b0; enable = 1'b1;
    run_until_valid(10, ok, bad);
    checks++; if (!ok) $display("FAIL ed_wait_valid: tvalid got %b want 1 within 10 cycles", axis_out_tvalid); else passed++;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (obs !== expected()) bad++;
      if (axis_out_tvalid !== 1'b1) dropped++;
    end
    checks++; if (dropped != 0) $display("FAIL ed_hold: got %0d cycles without tvalid want 0", dropped); else passed++;
    axis_out_tready = 1'b1;
    step();
    if (obs !== expected()) bad++;
    checks++; if (total_sent_packets !== 1) $display("FAIL ed_one_handshake: total got %0d want 1", total_sent_packets); else passed++;
    checks++; if (axis_out_tvalid !== 1'b0) $display("FAIL ed_tvalid_low: got %b want 0", axis_out_tvalid); else passed++;
    step();
    step();
    if (obs !== expected()) bad++;
    checks++; if (axis_out_tvalid !== 1'b0 || total_sent_packets !== 1) $display("FAIL ed_stays_idle: tvalid %b total %0d want 0 and 1", axis_out_tvalid, total_sent_packets); else passed++;
    checks++; if (bad != 0) $display("FAIL ed_model: got %0d mismatching cycles want 0", bad); else passed++;
    $display("test_enable_drop done");
  endtask

  task automatic test_rate();
    int bad = 0, zero_flits = 0, flits = 0, gaps = 0;
    apply_reset();
    num_packets = '0; inject_rate = 9'd0; axis_out_tready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (obs !== expected()) bad++;
      if (axis_out_tvalid !== 1'b0) zero_flits++;
    end
    checks++; if (zero_flits != 0) $display("FAIL rate0_no_flits: got %0d valid cycles want 0", zero_flits); else passed++;
    inject_rate = 9'd64;
    for (int i = 0; i < 25600; i++) begin
      if (axis_out_tvalid === 1'b1) begin
        flits++;
        if (int'(axis_out_tdata[CW-1:0]) != seen[axis_out_tdest]) gaps++;
        seen[axis_out_tdest]++;
      end
      step();
      if (obs !== expected()) bad++;
    end
    checks++; if (flits < 6080 || flits > 6720) $display("FAIL rate64_count: got %0d want 6080..6720", flits); else passed++;
    checks++; if (gaps != 0) $display("FAIL rate64_seq_gapfree: got %0d bad sequence numbers want 0", gaps); else passed++;
    checks++; if (bad != 0) $display("FAIL rate_model: got %0d mismatching cycles want 0", bad); else passed++;
    $display("test_rate done: %0d flits at rate 64", flits);
  endtask

  task automatic test_random();
    int bad = 0, done_cycles = 0;
    apply_reset();
    num_packets = 300; inject_rate = 9'd200; enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) inject_rate = 9'($urandom_range(0, 256));
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      if (i == 1500) num_packets = m_total + 20;
      axis_out_tready = ($urandom_range(0, 3) != 0);
      step();
      if (obs !== expected()) bad++;
      if (done === 1'b1) done_cycles++;
    end
    checks++; if (bad != 0) $display("FAIL random_model: got %0d mismatching cycles want 0", bad); else passed++;
    $display("test_random done: total %0d, %0d cycles in done", total_sent_packets, done_cycles);
  endtask

  task automatic test_reset_replay();
    bit pat [200];
    logic [CW+DW-1:0] q1 [$];
    logic [CW+DW-1:0] q2 [$];
    int bad = 0, diff = 0;
    bit ok;
    for (int i = 0; i < 200; i++) pat[i] = ($urandom_range(0, 2) != 0);
    apply_reset();
    num_packets = '0; inject_rate = 9'd128; enable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      axis_out_tready = pat[i];
      if (axis_out_tvalid === 1'b1 && pat[i]) q1.push_back({axis_out_tdest, axis_out_tdata[CW-1:0]});
      step();
      if (obs !== expected()) bad++;
    end
    axis_out_tready = 1'b0;
    run_until_valid(50, ok, bad);
    checks++; if (!ok) $display("FAIL replay_reach_valid: tvalid got %b want 1", axis_out_tvalid); else passed++;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (axis_out_tvalid !== 1'b0) $display("FAIL replay_reset_tvalid: got %b want 0", axis_out_tvalid); else passed++;
    checks++; if (total_sent_packets !== '0 || sent_packets !== '0) $display("FAIL replay_reset_counters: total %0d sent %h want 0", total_sent_packets, sent_packets); else passed++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      axis_out_tready = pat[i];
      if (axis_out_tvalid === 1'b1 && pat[i]) q2.push_back({axis_out_tdest, axis_out_tdata[CW-1:0]});
      step();
      if (obs !== expected()) bad++;
    end
    checks++; if (q1.size() == 0 || q2.size() != q1.size()) $display("FAIL replay_count: got %0d flits want %0d (nonzero)", q2.size(), q1.size()); else passed++;
    for (int i = 0; i < q1.size() && i < q2.size(); i++) if (q1[i] !== q2[i]) diff++;
    checks++; if (diff != 0) $display("FAIL replay_sequence: got %0d differing flits want 0", diff); else passed++;
    checks++; if (bad != 0) $display("FAIL replay_model: got %0d mismatching cycles want 0", bad); else passed++;
    $display("test_reset_replay done: %0d flits per pass", q1.size());
  endtask

  task automatic test_self_dest();
    int bad = 0, flits = 0, self_hits = 0, gaps = 0;
    apply_reset();
    num_packets = '0; inject_rate = 9'd256; axis_out_tready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 10010; i++) begin
      if (axis_out_tvalid === 1'b1) begin
        flits++;
        if (axis_out_tdest == DW'(TIDP)) self_hits++;
        if (int'(axis_out_tdata[CW-1:0]) != seen[axis_out_tdest]) gaps++;
        seen[axis_out_tdest]++;
      end
      step();
      if (obs !== expected()) bad++;
    end
    checks++; if (flits < 10000) $display("FAIL self_flit_count: got %0d want >= 10000", flits); else passed++;
`ifdef AXIS_TRAFFIC_GEN_SKIP_SELF_EN
    checks++; if (self_hits != 0) $display("FAIL self_skipped: got %0d flits to own id want 0", self_hits); else passed++;
`else
    checks++; if (self_hits == 0) $display("FAIL self_present: got %0d flits to own id want > 0", self_hits); else passed++;
`endif
    checks++; if (gaps != 0) $display("FAIL self_seq_gapfree: got %0d bad sequence numbers want 0", gaps); else passed++;
    checks++; if (bad != 0) $display("FAIL self_model: got %0d mismatching cycles want 0", bad); else passed++;
    $display("test_self_dest done: %0d flits, %0d to own id", flits, self_hits);
  endtask

  initial begin
    test_reset();
    test_budget();
    test_backpressure();
    test_enable_drop();
    test_rate();
    test_random();
    test_reset_replay();
    test_self_dest();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation still running at time limit, %0d/%0d checks so far", passed, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
